slave_write: RTL and testbench

AXI write-channel responder for an on-chip SRAM slave. It accepts one write burst at a time on the AW/W channels, converts each accepted data beat into a synchronous SRAM byte-masked word write, and returns a single B response. It sits between the AXI interconnect's slave port and the SRAM macro, and is the counterpart of the CPU-side write master.

---
 rtl/axi_pkg.sv | 40 ++++
 rtl/axi_burst_addr.sv | 57 +++++
 rtl/slave_write.sv | 129 ++++++++++++
 tb/tb_slave_write.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI write-channel widths, FSM state type and the
//               response / burst-type encodings used by the SRAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    // Channel widths
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = 4;
    localparam int AXI_LEN_BITS  = 4;

    // Write responder states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    // BRESP encodings
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // AWBURST encodings
    localparam logic [1:0] FIXED = 2'd0;
    localparam logic [1:0] INCR  = 2'd1;
    localparam logic [1:0] WRAP  = 2'd2;

    // Every burst type except FIXED walks the word index forward; WRAP is
    // handled as a plain incrementing burst.
    function automatic logic burst_advances(input logic [1:0] burst);
        return burst != FIXED;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr
// Description : Burst word-index generator. Loads a start index, length and
//               advance mode on the address handshake, then on each accepted
//               beat bumps the beat counter and (for incrementing bursts) the
//               word index modulo 2^SRAM_AW. Flags when the current beat is
//               the one the address phase declared as last.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr #(
    parameter int SRAM_AW = 14,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [SRAM_AW-1:0] load_idx,
    input  logic [LEN_W-1:0]   load_len,
    input  logic               load_incr,
    input  logic               advance,
    output logic [SRAM_AW-1:0] word_idx,
    output logic [LEN_W-1:0]   beat_cnt,
    output logic               last_beat
);

    logic [SRAM_AW-1:0] r_idx;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_incr;

    // Load burst parameters on address accept, step on every accepted beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx  <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_incr <= 1'b0;
        end else if (load) begin
            r_idx  <= load_idx;
            r_len  <= load_len;
            r_cnt  <= '0;
            r_incr <= load_incr;
        end else if (advance) begin
            if (r_incr) begin
                r_idx <= r_idx + SRAM_AW'(1);
            end
            r_cnt <= r_cnt + LEN_W'(1);
        end
    end

    assign word_idx  = r_idx;
    assign beat_cnt  = r_cnt;
    assign last_beat = (r_cnt == r_len);

endmodule
`default_nettype wire

// File: rtl/slave_write.sv
`default_nettype none
// ============================================================================
// Module      : slave_write
// Description : AXI write-channel responder for an on-chip SRAM. Accepts one
//               burst at a time, turns each W beat into a byte-masked SRAM
//               word write in the same cycle, and returns a single B
//               response (SLVERR when WLAST disagrees with AWLEN).
// Revision    : 1.0 - initial release
// ============================================================================
module slave_write
    import axi_pkg::*;
#(
    parameter int SRAM_AW = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_IDS_BITS-1:0]  AWID_S,
    input  logic [AXI_ADDR_BITS-1:0] AWADDR_S,
    input  logic [AXI_LEN_BITS-1:0]  AWLEN_S,
    input  logic [2:0]               AWSIZE_S,
    input  logic [1:0]               AWBURST_S,
    input  logic                     AWVALID_S,
    output logic                     AWREADY_S,
    input  logic [AXI_DATA_BITS-1:0] WDATA_S,
    input  logic [AXI_STRB_BITS-1:0] WSTRB_S,
    input  logic                     WLAST_S,
    input  logic                     WVALID_S,
    output logic                     WREADY_S,
    output logic [AXI_IDS_BITS-1:0]  BID_S,
    output logic [1:0]               BRESP_S,
    output logic                     BVALID_S,
    input  logic                     BREADY_S,
    output logic                     sram_CEB,
    output logic [AXI_STRB_BITS-1:0] sram_WEB,
    output logic [SRAM_AW-1:0]       sram_A,
    output logic [AXI_DATA_BITS-1:0] sram_DI
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [AXI_IDS_BITS-1:0]  r_id;
    logic                     r_err;

    logic                     w_aw_hs;
    logic                     w_w_hs;
    logic                     w_term;
    logic [SRAM_AW-1:0]       w_word_idx;
    logic [AXI_LEN_BITS-1:0]  w_beat_cnt;
    logic                     w_last_beat;
    logic                     w_unused;

    // Size is fixed at 32-bit words and only the word-index address bits matter
    assign w_unused = ^{AWSIZE_S, AWADDR_S[AXI_ADDR_BITS-1:SRAM_AW+2],
                        AWADDR_S[1:0], w_beat_cnt};

    assign w_aw_hs = (r_state == IDLE) && AWVALID_S;
    assign w_w_hs  = (r_state == DATA) && WVALID_S;
    // The burst closes on whichever comes first: WLAST or the AWLEN-th beat
    assign w_term  = w_w_hs && (WLAST_S || w_last_beat);

    axi_burst_addr #(
        .SRAM_AW (SRAM_AW),
        .LEN_W   (AXI_LEN_BITS)
    ) u_burst_addr (
        .clk       (clk),
        .rst       (rst),
        .load      (w_aw_hs),
        .load_idx  (AWADDR_S[SRAM_AW+1:2]),
        .load_len  (AWLEN_S),
        .load_incr (burst_advances(AWBURST_S)),
        .advance   (w_w_hs),
        .word_idx  (w_word_idx),
        .beat_cnt  (w_beat_cnt),
        .last_beat (w_last_beat)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (AWVALID_S) w_state_nxt = DATA;
            DATA:    if (w_term)    w_state_nxt = RESP;
            RESP:    if (BREADY_S)  w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Capture the ID at address accept; latch the WLAST/AWLEN agreement on the closing beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id  <= '0;
            r_err <= 1'b0;
        end else if (w_aw_hs) begin
            r_id  <= AWID_S;
            r_err <= 1'b0;
        end else if (w_term) begin
            r_err <= WLAST_S ^ w_last_beat;
        end
    end

    // Channel handshakes and SRAM strobes decoded from the current state
    always_comb begin
        AWREADY_S = (r_state == IDLE);
        WREADY_S  = (r_state == DATA);
        BVALID_S  = (r_state == RESP);
        BID_S     = r_id;
        BRESP_S   = r_err ? SLVERR : OKAY;
        sram_DI   = WDATA_S;
        sram_CEB  = 1'b1;
        sram_WEB  = '1;
        sram_A    = '0;
        if (w_w_hs) begin
            sram_CEB = 1'b0;
            sram_WEB = ~WSTRB_S;
            sram_A   = w_word_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slave_write.sv
`default_nettype none
// ============================================================================
// Module      : tb_slave_write
// Description : Self-checking bench for slave_write. Bursts are described as
//               beat tables; a reference model derives the expected SRAM
//               writes and B response directly from the burst rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_write;

    typedef logic [49:0] wr_t;   // {word address, WEB, data}

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  AWID_S;
    logic [31:0] AWADDR_S;
    logic [3:0]  AWLEN_S;
    logic [2:0]  AWSIZE_S;
    logic [1:0]  AWBURST_S;
    logic        AWVALID_S;
    logic        AWREADY_S;
    logic [31:0] WDATA_S;
    logic [3:0]  WSTRB_S;
    logic        WLAST_S;
    logic        WVALID_S;
    logic        WREADY_S;
    logic [7:0]  BID_S;
    logic [1:0]  BRESP_S;
    logic        BVALID_S;
    logic        BREADY_S;
    logic        sram_CEB;
    logic [3:0]  sram_WEB;
    logic [13:0] sram_A;
    logic [31:0] sram_DI;

    int vectors    = 0;
    int miscompares = 0;

    // Beat table for the burst being driven
    logic [31:0] b_data [16];
    logic [3:0]  b_strb [16];
    logic        b_last [16];
    int          nb;

    // Observations from the last burst
    wr_t  obs_wr[$];
    logic [7:0] obs_bid;
    logic [1:0] obs_bresp;
    int   obs_b_gap;
    logic obs_to;
    logic obs_wready_first;
    logic obs_stable;
    logic obs_awready_after;

    // Expectations from the reference model
    wr_t  exp_wr[$];
    logic [1:0] exp_resp;

    slave_write #(.SRAM_AW(14)) dut (
        .clk(clk), .rst(rst),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
        .AWSIZE_S(AWSIZE_S), .AWBURST_S(AWBURST_S),
        .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
        .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .sram_CEB(sram_CEB), .sram_WEB(sram_WEB), .sram_A(sram_A), .sram_DI(sram_DI)
    );

    always #5 clk = ~clk;

    // Fill the beat table: random data/strobes, WLAST only on beat last_at (-1 = never)
    task automatic fill_beats(input int len, input int last_at);
        nb = len + 1;
        for (int i = 0; i < 16; i++) begin
            b_data[i] = $urandom;
            b_strb[i] = 4'($urandom_range(15));
            b_last[i] = (i == last_at);
        end
    endtask

    // Reference model: writes and response implied by the burst rules
    task automatic model(input logic [31:0] addr, input int len, input logic [1:0] burst);
        logic [13:0] idx;
        logic        err;
        exp_wr.delete();
        idx = addr[15:2];
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            exp_wr.push_back({idx, ~b_strb[i], b_data[i]});
            if (burst != 2'd0) idx = idx + 14'd1;
            if (b_last[i] || i == len) begin
                err = (b_last[i] != (i == len));
                break;
            end
        end
        exp_resp = err ? 2'b10 : 2'b00;
    endtask

    // Drive one full burst (AW, W with random stalls, B with back-pressure); starts/ends at a negedge
    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int stall_pct, input int bdelay);
        int   cyc;
        int   k;
        int   last_hs;
        logic done;
        obs_wr.delete();
        obs_to = 1'b0;
        obs_stable = 1'b1;
        obs_b_gap = -1;
        obs_wready_first = 1'b0;
        obs_awready_after = 1'b0;
        AWID_S = id; AWADDR_S = addr; AWLEN_S = 4'(len); AWBURST_S = burst;
        AWSIZE_S = 3'($urandom_range(7)); AWVALID_S = 1'b1;
        cyc = 0;
        #2;
        while (!AWREADY_S && cyc < 50) begin
            @(negedge clk); #2; cyc++;
        end
        if (!AWREADY_S) begin
            obs_to = 1'b1; AWVALID_S = 1'b0; @(negedge clk); return;
        end
        @(negedge clk);
        AWVALID_S = 1'b0;
        AWADDR_S = $urandom;
        k = 0; cyc = 0; last_hs = -1; done = 1'b0;
        while (!done && cyc < 300) begin
            WVALID_S = (k < nb) && ($urandom_range(99) >= stall_pct);
            if (k < nb) begin
                WDATA_S = b_data[k]; WSTRB_S = b_strb[k]; WLAST_S = b_last[k];
            end
            #2;
            if (cyc == 0) obs_wready_first = WREADY_S;
            if (BVALID_S) begin
                done = 1'b1;
                obs_b_gap = cyc - last_hs;
            end else begin
                if (!sram_CEB) obs_wr.push_back({sram_A, sram_WEB, sram_DI});
                if (WVALID_S && WREADY_S) begin k++; last_hs = cyc; end
                @(negedge clk);
                cyc++;
            end
        end
        WVALID_S = 1'b0;
        if (!done) begin obs_to = 1'b1; return; end
        obs_bid = BID_S;
        obs_bresp = BRESP_S;
        BREADY_S = 1'b0;
        repeat (bdelay) begin
            @(negedge clk); #2;
            if (!BVALID_S || BID_S !== obs_bid || BRESP_S !== obs_bresp || AWREADY_S) obs_stable = 1'b0;
        end
        @(negedge clk);
        BREADY_S = 1'b1;
        #2;
        if (!BVALID_S || AWREADY_S) obs_stable = 1'b0;
        @(negedge clk);
        BREADY_S = 1'b0;
        #2;
        obs_awready_after = AWREADY_S && !BVALID_S;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWSIZE_S = '0; AWBURST_S = '0;
        AWVALID_S = 1'b0; WDATA_S = '0; WSTRB_S = '0; WLAST_S = 1'b0;
        WVALID_S = 1'b0; BREADY_S = 1'b0;
        @(negedge clk); #2;
        vectors++; if (AWREADY_S !== 1'b1) begin miscompares++; $display("FAIL reset_awready: got %b want 1", AWREADY_S); end
        vectors++; if (WREADY_S !== 1'b0) begin miscompares++; $display("FAIL reset_wready: got %b want 0", WREADY_S); end
        vectors++; if (BVALID_S !== 1'b0) begin miscompares++; $display("FAIL reset_bvalid: got %b want 0", BVALID_S); end
        vectors++; if ({BID_S, BRESP_S} !== 10'h0) begin miscompares++; $display("FAIL reset_b: got %h/%b want 0/00", BID_S, BRESP_S); end
        vectors++; if ({sram_CEB, sram_WEB, sram_A} !== {1'b1, 4'hF, 14'h0}) begin
            miscompares++; $display("FAIL reset_sram: got ceb=%b web=%b a=%h want 1/1111/0", sram_CEB, sram_WEB, sram_A);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_beat;
        fill_beats(0, 0);
        b_data[0] = 32'hDEADBEEF; b_strb[0] = 4'hF;
        model(32'h0000_0010, 0, 2'd1);
        run_burst(8'h15, 32'h0000_0010, 0, 2'd1, 0, 0);
        vectors++; if (obs_to !== 1'b0) begin miscompares++; $display("FAIL single_timeout: got %b want 0", obs_to); end
        vectors++; if (obs_wready_first !== 1'b1) begin miscompares++; $display("FAIL single_wready_lat: got %b want 1", obs_wready_first); end
        vectors++; if (obs_wr.size() !== 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", obs_wr.size()); end
        vectors++; if (obs_wr.size() > 0 && obs_wr[0] !== {14'h4, 4'h0, 32'hDEADBEEF}) begin
            miscompares++; $display("FAIL single_write: got %h want %h", obs_wr[0], {14'h4, 4'h0, 32'hDEADBEEF});
        end
        vectors++; if (obs_bid !== 8'h15) begin miscompares++; $display("FAIL single_bid: got %h want 15", obs_bid); end
        vectors++; if (obs_bresp !== 2'b00) begin miscompares++; $display("FAIL single_bresp: got %b want 00", obs_bresp); end
        vectors++; if (obs_b_gap !== 1) begin miscompares++; $display("FAIL single_b_latency: got %0d want 1", obs_b_gap); end
        vectors++; if (obs_awready_after !== 1'b1) begin miscompares++; $display("FAIL single_awready_after: got %b want 1", obs_awready_after); end
    endtask

    task automatic test_incr_stall;
        fill_beats(3, 3);
        model(32'h0000_0100, 3, 2'd1);
        run_burst(8'h3C, 32'h0000_0100, 3, 2'd1, 50, 1);
        vectors++; if (obs_to !== 1'b0) begin miscompares++; $display("FAIL incr_timeout: got %b want 0", obs_to); end
        vectors++; if (obs_wr.size() !== 4) begin miscompares++; $display("FAIL incr_count: got %0d want 4", obs_wr.size()); end
        for (int i = 0; i < 4 && i < obs_wr.size(); i++) begin
            vectors++; if (obs_wr[i] !== exp_wr[i] || obs_wr[i][49:36] !== 14'(14'h40 + i)) begin
                miscompares++; $display("FAIL incr_write%0d: got %h want %h", i, obs_wr[i], exp_wr[i]);
            end
        end
        vectors++; if (obs_b_gap !== 1) begin miscompares++; $display("FAIL incr_b_latency: got %0d want 1", obs_b_gap); end
        vectors++; if (obs_bresp !== 2'b00) begin miscompares++; $display("FAIL incr_bresp: got %b want 00", obs_bresp); end
    endtask

    task automatic test_fixed_strobe;
        fill_beats(1, 1);
        b_strb[0] = 4'b0101; b_strb[1] = 4'b1000;
        model(32'h0000_2468, 1, 2'd0);
        run_burst(8'hA7, 32'h0000_2468, 1, 2'd0, 20, 0);
        vectors++; if (obs_wr.size() !== 2) begin miscompares++; $display("FAIL fixed_count: got %0d want 2", obs_wr.size()); end
        for (int i = 0; i < 2 && i < obs_wr.size(); i++) begin
            vectors++; if (obs_wr[i] !== exp_wr[i]) begin
                miscompares++; $display("FAIL fixed_write%0d: got %h want %h", i, obs_wr[i], exp_wr[i]);
            end
        end
        vectors++; if (obs_wr.size() == 2 && {obs_wr[0][35:32], obs_wr[1][35:32]} !== 8'b1010_0111) begin
            miscompares++; $display("FAIL fixed_web: got %b/%b want 1010/0111", obs_wr[0][35:32], obs_wr[1][35:32]);
        end
        vectors++; if (obs_bid !== 8'hA7) begin miscompares++; $display("FAIL fixed_bid: got %h want a7", obs_bid); end
    endtask

    task automatic test_errors;
        // Early WLAST on the second beat of a four-beat burst
        fill_beats(3, 1);
        model(32'h0000_0800, 3, 2'd1);
        run_burst(8'h01, 32'h0000_0800, 3, 2'd1, 30, 0);
        vectors++; if (obs_wr.size() !== 2) begin miscompares++; $display("FAIL early_count: got %0d want 2", obs_wr.size()); end
        for (int i = 0; i < 2 && i < obs_wr.size(); i++) begin
            vectors++; if (obs_wr[i] !== exp_wr[i]) begin miscompares++; $display("FAIL early_write%0d: got %h want %h", i, obs_wr[i], exp_wr[i]); end
        end
        vectors++; if (obs_bresp !== 2'b10) begin miscompares++; $display("FAIL early_bresp: got %b want 10", obs_bresp); end
        // No WLAST at all on a two-beat burst
        fill_beats(1, -1);
        model(32'h0000_0C00, 1, 2'd1);
        run_burst(8'h02, 32'h0000_0C00, 1, 2'd1, 30, 0);
        vectors++; if (obs_wr.size() !== 2) begin miscompares++; $display("FAIL nolast_count: got %0d want 2", obs_wr.size()); end
        vectors++; if (obs_bresp !== 2'b10) begin miscompares++; $display("FAIL nolast_bresp: got %b want 10", obs_bresp); end
        vectors++; if (obs_b_gap !== 1) begin miscompares++; $display("FAIL nolast_b_latency: got %0d want 1", obs_b_gap); end
    endtask

    task automatic test_wrap_backpressure;
        fill_beats(1, 1);
        model(32'h0000_FFFC, 1, 2'd1);
        run_burst(8'h5A, 32'h0000_FFFC, 1, 2'd1, 0, 5);
        vectors++; if (obs_wr.size() !== 2) begin miscompares++; $display("FAIL wrap_count: got %0d want 2", obs_wr.size()); end
        vectors++; if (obs_wr.size() == 2 && {obs_wr[0][49:36], obs_wr[1][49:36]} !== {14'h3FFF, 14'h0000}) begin
            miscompares++; $display("FAIL wrap_addr: got %h/%h want 3fff/0000", obs_wr[0][49:36], obs_wr[1][49:36]);
        end
        vectors++; if (obs_stable !== 1'b1) begin miscompares++; $display("FAIL bp_stable: got %b want 1", obs_stable); end
        vectors++; if (obs_bid !== 8'h5A) begin miscompares++; $display("FAIL bp_bid: got %h want 5a", obs_bid); end
        vectors++; if (obs_awready_after !== 1'b1) begin miscompares++; $display("FAIL bp_awready_after: got %b want 1", obs_awready_after); end
    endtask

    task automatic test_reset_mid_burst;
        logic wrote;
        AWID_S = 8'h77; AWADDR_S = 32'h0000_0400; AWLEN_S = 4'd3; AWBURST_S = 2'd1; AWVALID_S = 1'b1;
        #2;
        vectors++; if (AWREADY_S !== 1'b1) begin miscompares++; $display("FAIL rstmid_aw: got %b want 1", AWREADY_S); end
        @(negedge clk);
        AWVALID_S = 1'b0;
        WVALID_S = 1'b1; WDATA_S = 32'h1234_5678; WSTRB_S = 4'hF; WLAST_S = 1'b0;
        #2;
        wrote = !sram_CEB && sram_A == 14'h100;
        vectors++; if (wrote !== 1'b1) begin miscompares++; $display("FAIL rstmid_beat1: got ceb=%b a=%h want 0/100", sram_CEB, sram_A); end
        @(negedge clk);
        WDATA_S = 32'h9ABC_DEF0;
        rst = 1'b0;
        #2;
        vectors++; if ({AWREADY_S, BVALID_S, sram_CEB} !== 3'b101) begin
            miscompares++; $display("FAIL rstmid_state: got aw=%b bv=%b ceb=%b want 1/0/1", AWREADY_S, BVALID_S, sram_CEB);
        end
        @(negedge clk);
        rst = 1'b1;
        WVALID_S = 1'b0;
        @(negedge clk);
        fill_beats(2, 2);
        model(32'h0000_0200, 2, 2'd1);
        run_burst(8'h78, 32'h0000_0200, 2, 2'd1, 0, 0);
        vectors++; if (obs_wr.size() !== 3) begin miscompares++; $display("FAIL rstmid_next_count: got %0d want 3", obs_wr.size()); end
        vectors++; if (obs_wr.size() == 3 && obs_wr[2] !== exp_wr[2]) begin
            miscompares++; $display("FAIL rstmid_next_write: got %h want %h", obs_wr[2], exp_wr[2]);
        end
        vectors++; if ({obs_bid, obs_bresp} !== {8'h78, 2'b00}) begin
            miscompares++; $display("FAIL rstmid_next_b: got %h/%b want 78/00", obs_bid, obs_bresp);
        end
    endtask

    task automatic test_random;
        int          len;
        int          last_at;
        int          r;
        logic [7:0]  id;
        logic [31:0] addr;
        logic [1:0]  burst;
        for (int n = 0; n < 30; n++) begin
            len = $urandom_range(15);
            r = $urandom_range(9);
            if (r < 7)      last_at = len;
            else if (r < 9) last_at = $urandom_range(len);
            else            last_at = -1;
            id = 8'($urandom);
            addr = $urandom;
            burst = 2'($urandom_range(2));
            fill_beats(len, last_at);
            model(addr, len, burst);
            run_burst(id, addr, len, burst, $urandom_range(60), $urandom_range(3));
            vectors++; if (obs_to !== 1'b0) begin miscompares++; $display("FAIL rand%0d_timeout: got %b want 0", n, obs_to); end
            vectors++; if (obs_wr.size() !== exp_wr.size()) begin
                miscompares++; $display("FAIL rand%0d_count: got %0d want %0d", n, obs_wr.size(), exp_wr.size());
            end
            for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
                vectors++; if (obs_wr[i] !== exp_wr[i]) begin
                    miscompares++; $display("FAIL rand%0d_write%0d: got %h want %h", n, i, obs_wr[i], exp_wr[i]);
                end
            end
            vectors++; if ({obs_bid, obs_bresp} !== {id, exp_resp}) begin
                miscompares++; $display("FAIL rand%0d_b: got %h/%b want %h/%b", n, obs_bid, obs_bresp, id, exp_resp);
            end
            vectors++; if ({obs_stable, obs_awready_after} !== 2'b11) begin
                miscompares++; $display("FAIL rand%0d_bhold: got %b%b want 11", n, obs_stable, obs_awready_after);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_incr_stall();
        test_fixed_strobe();
        test_errors();
        test_wrap_backpressure();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
